// File: rtl/sdram_pkg.sv
// -----------------------------------------------------------------------------
// sdram_pkg
// Shared definitions for the SDRAM pin arbiter:
//   - SDRAM command encodings as 4-bit {cs#, ras#, cas#, we#}
//   - arbiter state encoding
//   - grant encoding produced by the priority block
// -----------------------------------------------------------------------------
package sdram_pkg;

    localparam logic [3:0] CMD_NOP          = 4'b0111;
    localparam logic [3:0] CMD_PRECHARGE    = 4'b0010;
    localparam logic [3:0] CMD_AUTO_REFRESH = 4'b0001;
    localparam logic [3:0] CMD_LOAD_MODE    = 4'b0000;
    localparam logic [3:0] CMD_ACTIVE       = 4'b0011;
    localparam logic [3:0] CMD_WRITE        = 4'b0100;
    localparam logic [3:0] CMD_READ         = 4'b0101;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_ARBIT = 3'd1,
        ST_AREF  = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4
    } arb_state_e;

    typedef enum logic [1:0] {
        GNT_NONE  = 2'd0,
        GNT_AREF  = 2'd1,
        GNT_WRITE = 2'd2,
        GNT_READ  = 2'd3
    } grant_e;

endpackage

// File: rtl/sdram_arb_prio.sv
// -----------------------------------------------------------------------------
// sdram_arb_prio
// Combinational grant selection for the SDRAM arbiter.
// Refresh always wins. A write/read tie goes to write, or, when the build
// defines SDRAM_ARB_RR_EN, to whichever of write/read was not served last.
// Ports:
//   aref_req, wr_req, rd_req  in   pending requests
//   last_served_wr            in   (SDRAM_ARB_RR_EN only) 1 = write served last
//   grant                     out  selected engine, GNT_NONE if no request
// -----------------------------------------------------------------------------
module sdram_arb_prio
    import sdram_pkg::*;
(
    input  logic   aref_req,
    input  logic   wr_req,
    input  logic   rd_req,
`ifdef SDRAM_ARB_RR_EN
    input  logic   last_served_wr,
`endif
    output grant_e grant
);

    always_comb begin
        grant = GNT_NONE;
        if (aref_req) begin
            grant = GNT_AREF;
        end else if (wr_req && rd_req) begin
`ifdef SDRAM_ARB_RR_EN
            grant = last_served_wr ? GNT_READ : GNT_WRITE;
`else
            grant = GNT_WRITE;
`endif
        end else if (wr_req) begin
            grant = GNT_WRITE;
        end else if (rd_req) begin
            grant = GNT_READ;
        end
    end

endmodule

// File: rtl/sdram_arbit.sv
// -----------------------------------------------------------------------------
// sdram_arbit
// Owns the SDRAM command/address/data pins. Passes the init sequencer through
// until init_end, then grants one of refresh/write/read engines at a time and
// muxes its command, bank and address onto the pins. Every grant is separated
// by at least one ARBIT cycle that issues NOP.
// Optional build macro: SDRAM_ARB_RR_EN (write/read alternate on a tie).
// Ports:
//   sys_clk, sys_rst_n                      clock, async active-low reset
//   init_cmd/ba/addr, init_end              init sequencer interface
//   aref_req/cmd/ba/addr/end, aref_en       refresh engine interface + grant
//   wr_req/cmd/ba/addr/end, wr_en           write engine interface + grant
//   wr_sdram_en, wr_sdram_data              write data for DQ
//   rd_req/cmd/ba/addr/end, rd_en           read engine interface + grant
//   sdram_cke, sdram_cs_n/ras_n/cas_n/we_n  SDRAM control pins
//   sdram_ba, sdram_addr                    SDRAM bank/address pins
//   sdram_dq_out, sdram_dq_oe               DQ drive value and enable
// -----------------------------------------------------------------------------
module sdram_arbit
    import sdram_pkg::*;
#(
    parameter int ADDR_W = 13,
    parameter int BA_W   = 2,
    parameter int DATA_W = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [3:0]        init_cmd,
    input  logic [BA_W-1:0]   init_ba,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic              init_end,
    input  logic              aref_req,
    input  logic [3:0]        aref_cmd,
    input  logic [BA_W-1:0]   aref_ba,
    input  logic [ADDR_W-1:0] aref_addr,
    input  logic              aref_end,
    input  logic              wr_req,
    input  logic [3:0]        wr_cmd,
    input  logic [BA_W-1:0]   wr_ba,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_end,
    input  logic              wr_sdram_en,
    input  logic [DATA_W-1:0] wr_sdram_data,
    input  logic              rd_req,
    input  logic [3:0]        rd_cmd,
    input  logic [BA_W-1:0]   rd_ba,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_end,
    output logic              aref_en,
    output logic              wr_en,
    output logic              rd_en,
    output logic              sdram_cke,
    output logic              sdram_cs_n,
    output logic              sdram_ras_n,
    output logic              sdram_cas_n,
    output logic              sdram_we_n,
    output logic [BA_W-1:0]   sdram_ba,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [DATA_W-1:0] sdram_dq_out,
    output logic              sdram_dq_oe
);

    arb_state_e  state_q, state_d;
    grant_e      grant;
    logic [3:0]  cmd;

`ifdef SDRAM_ARB_RR_EN
    logic last_wr_q, last_wr_d;
`endif

    sdram_arb_prio u_prio (
        .aref_req       (aref_req),
        .wr_req         (wr_req),
        .rd_req         (rd_req),
`ifdef SDRAM_ARB_RR_EN
        .last_served_wr (last_wr_q),
`endif
        .grant          (grant)
    );

    // Next-state logic. Requests are only looked at in ARBIT; in a granted
    // state only the owning engine's end pulse matters.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_INIT:  if (init_end) state_d = ST_ARBIT;
            ST_ARBIT: begin
                unique case (grant)
                    GNT_AREF:  state_d = ST_AREF;
                    GNT_WRITE: state_d = ST_WRITE;
                    GNT_READ:  state_d = ST_READ;
                    default:   state_d = ST_ARBIT;
                endcase
            end
            ST_AREF:  if (aref_end) state_d = ST_ARBIT;
            ST_WRITE: if (wr_end)   state_d = ST_ARBIT;
            ST_READ:  if (rd_end)   state_d = ST_ARBIT;
            default:  state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef SDRAM_ARB_RR_EN
    // Remembers whether write or read was granted most recently; resets to
    // "read" so that the first write/read tie goes to write.
    always_comb begin
        last_wr_d = last_wr_q;
        if (state_q == ST_ARBIT) begin
            if (grant == GNT_WRITE) last_wr_d = 1'b1;
            if (grant == GNT_READ)  last_wr_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            last_wr_q <= 1'b0;
        end else begin
            last_wr_q <= last_wr_d;
        end
    end
`endif

    // Grants are decoded straight from the state register.
    assign aref_en = (state_q == ST_AREF);
    assign wr_en   = (state_q == ST_WRITE);
    assign rd_en   = (state_q == ST_READ);

    // Pin mux. ARBIT (and anything unexpected) parks the bus on NOP with
    // bank/address all-ones. While reset is held the state is already INIT,
    // so the init pass-through is gated by sys_rst_n to make the pins show
    // NOP in the same instant reset asserts.
    always_comb begin
        cmd        = CMD_NOP;
        sdram_ba   = '1;
        sdram_addr = '1;
        unique case (state_q)
            ST_INIT: begin
                if (sys_rst_n) begin
                    cmd        = init_cmd;
                    sdram_ba   = init_ba;
                    sdram_addr = init_addr;
                end
            end
            ST_AREF: begin
                cmd        = aref_cmd;
                sdram_ba   = aref_ba;
                sdram_addr = aref_addr;
            end
            ST_WRITE: begin
                cmd        = wr_cmd;
                sdram_ba   = wr_ba;
                sdram_addr = wr_addr;
            end
            ST_READ: begin
                cmd        = rd_cmd;
                sdram_ba   = rd_ba;
                sdram_addr = rd_addr;
            end
            default: ;
        endcase
    end

    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;
    assign sdram_cke    = 1'b1;
    assign sdram_dq_oe  = (state_q == ST_WRITE) && wr_sdram_en;
    assign sdram_dq_out = sdram_dq_oe ? wr_sdram_data : '0;

endmodule
